// File: rtl/psw_pkg.sv
// psw_pkg: shared constants and types for the password datapath.
//   DIGIT_W       - bits per key-map digit
//   NUM_KEYS      - physical keypad buttons
//   KEYMAP_W      - packed key-map width (NUM_KEYS digits)
//   LFSR_TAP_MASK - feedback taps 16,14,13,11 of a right-shifting Fibonacci LFSR
//   IDENTITY_MAP  - button b shows digit b
//   shuf_state_e  - key-map shuffle FSM states
package psw_pkg;

   localparam int unsigned DIGIT_W  = 4;
   localparam int unsigned NUM_KEYS = 10;
   localparam int unsigned KEYMAP_W = NUM_KEYS * DIGIT_W;

   // taps 16,14,13,11 map to bits 0,2,3,5 when the register shifts right
   localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

   localparam logic [KEYMAP_W-1:0] IDENTITY_MAP = 40'h98_7654_3210;

   typedef enum logic {
      IDLE,
      SHUF
   } shuf_state_e;

endpackage

// File: rtl/keymap_shuffler.sv
// keymap_shuffler: free-running LFSR plus a 9-step Fisher-Yates shuffle of the
// keypad key map.
//   clk            - clock
//   nreset_i       - asynchronous active-low reset (restores identity map)
//   shuffle_init_i - start a shuffle (ignored while busy)
//   map_o          - digit shown on button b at [4b+3:4b]
//   busy_o         - shuffle in progress
module keymap_shuffler
   import psw_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                clk,
   input  logic                nreset_i,
   input  logic                shuffle_init_i,
   output logic [KEYMAP_W-1:0] map_o,
   output logic                busy_o
);

   shuf_state_e         state_q, state_d;
   logic [3:0]          idx_q, idx_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic [KEYMAP_W-1:0] map_q, map_d;
   logic [11:0]         prod;
   logic [3:0]          jdx;
   logic [3:0]          dig_i, dig_j;

   assign lfsr_d = {^(lfsr_q & LFSR_TAP_MASK), lfsr_q[15:1]};

   // j = (lfsr[7:0] * (i+1)) >> 8 always lands in 0..i
   assign prod = {4'd0, lfsr_q[7:0]} * {8'd0, idx_q + 4'd1};
   assign jdx  = 4'(prod >> 8);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      map_d   = map_q;
      dig_i   = map_q[{idx_q, 2'b00} +: 4];
      dig_j   = map_q[{jdx, 2'b00} +: 4];
      case (state_q)
         IDLE: begin
            if (shuffle_init_i) begin
               state_d = SHUF;
               idx_d   = 4'd9;
            end
         end
         SHUF: begin
            map_d[{idx_q, 2'b00} +: 4] = dig_j;
            map_d[{jdx, 2'b00} +: 4]   = dig_i;
            idx_d = idx_q - 4'd1;
            if (idx_q == 4'd1) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         lfsr_q  <= LFSR_SEED;
         map_q   <= IDENTITY_MAP;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lfsr_q  <= lfsr_d;
         map_q   <= map_d;
      end
   end

   assign map_o  = map_q;
   assign busy_o = (state_q == SHUF);

endmodule

// File: rtl/psw_datapath.sv
// psw_datapath: password datapath opposite the doorlock control FSM.
// Synchronizes and decodes keypad presses through a shufflable key map, and
// holds the stored password (mem) and entry buffer (buff) shift registers.
//   key_i          - raw button levels (async)
//   shuffle_init_i - start key-map shuffle
//   mem_rst_i/mem_sl_i, buff_rst_i/buff_sl_i - clear / shift-in pending digit
//   input_valid_o  - one-cycle pulse per accepted digit
//   same_o         - buff equals mem (registered)
//   master_same_o  - buff equals MASTER_PSW (registered)
//   mem_limit_o/buff_limit_o - register full
//   key_map_o      - current key map for the display
//   shuffle_busy_o - shuffle in progress
module psw_datapath
   import psw_pkg::NUM_KEYS;
   import psw_pkg::KEYMAP_W;
#(
   parameter int unsigned MAX_DIGITS = 8,
   parameter int unsigned DIGIT_W    = 4,
   parameter int unsigned MASTER_LEN = 8,
   parameter logic [MASTER_LEN*DIGIT_W-1:0] MASTER_PSW = 32'h2580_1379,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                clk,
   input  logic                nreset_i,
   input  logic [NUM_KEYS-1:0] key_i,
   input  logic                shuffle_init_i,
   input  logic                mem_rst_i,
   input  logic                mem_sl_i,
   input  logic                buff_rst_i,
   input  logic                buff_sl_i,
   output logic                input_valid_o,
   output logic                same_o,
   output logic                master_same_o,
   output logic                mem_limit_o,
   output logic                buff_limit_o,
   output logic [KEYMAP_W-1:0] key_map_o,
   output logic                shuffle_busy_o
);

   localparam int unsigned DATA_W = MAX_DIGITS * DIGIT_W;
   localparam int unsigned CNT_W  = $clog2(MAX_DIGITS + 1);
   localparam int unsigned MPSW_W = MASTER_LEN * DIGIT_W;

   logic [NUM_KEYS-1:0] key_s1_q, key_s_q;
   logic                press_q, press_d, bad_q, bad_d, valid_q, valid_d;
   logic [3:0]          btn_q, btn_d, key_idx, key_digit;
   logic [DIGIT_W-1:0]  pending_q, pending_d;
   logic [DATA_W-1:0]   mem_q, buff_q;
   logic [CNT_W-1:0]    mem_cnt_q, buff_cnt_q;
   logic                same_q, master_q;
   logic [KEYMAP_W-1:0] key_map;
   logic                busy;

   keymap_shuffler #(
      .LFSR_SEED(LFSR_SEED)
   ) u_shuffler (
      .clk           (clk),
      .nreset_i      (nreset_i),
      .shuffle_init_i(shuffle_init_i),
      .map_o         (key_map),
      .busy_o        (busy)
   );

   always_comb begin
      key_idx = '0;
      for (int unsigned b = 0; b < NUM_KEYS; b++)
         if (key_s_q[b]) key_idx = 4'(b);
   end

   always_comb begin
      key_digit = '0;
      for (int unsigned b = 0; b < NUM_KEYS; b++)
         if (btn_q == 4'(b)) key_digit = key_map[4*b +: 4];
   end

   // A press spans key_s != 0; the digit is decoded on release using the
   // map in force at that moment, so a shuffle ending mid-press is honoured.
   always_comb begin
      press_d   = press_q;
      bad_d     = bad_q;
      btn_d     = btn_q;
      valid_d   = 1'b0;
      pending_d = pending_q;
      if (key_s_q != '0) begin
         press_d = 1'b1;
         if (!$onehot(key_s_q)) bad_d = 1'b1;
         else                   btn_d = key_idx;
      end else if (press_q) begin
         press_d = 1'b0;
         bad_d   = 1'b0;
         if (!bad_q && !busy) begin
            valid_d   = 1'b1;
            pending_d = DIGIT_W'(key_digit);
         end
      end
   end

   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) begin
         key_s1_q  <= '0;
         key_s_q   <= '0;
         press_q   <= 1'b0;
         bad_q     <= 1'b0;
         btn_q     <= '0;
         valid_q   <= 1'b0;
         pending_q <= '0;
      end else begin
         key_s1_q  <= key_i;
         key_s_q   <= key_s1_q;
         press_q   <= press_d;
         bad_q     <= bad_d;
         btn_q     <= btn_d;
         valid_q   <= valid_d;
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) begin
         mem_q     <= '0;
         mem_cnt_q <= '0;
      end else if (mem_rst_i) begin
         mem_q     <= '0;
         mem_cnt_q <= '0;
      end else if (mem_sl_i && mem_cnt_q != CNT_W'(MAX_DIGITS)) begin
         mem_q     <= {mem_q[DATA_W-DIGIT_W-1:0], pending_q};
         mem_cnt_q <= mem_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) begin
         buff_q     <= '0;
         buff_cnt_q <= '0;
      end else if (buff_rst_i) begin
         buff_q     <= '0;
         buff_cnt_q <= '0;
      end else if (buff_sl_i && buff_cnt_q != CNT_W'(MAX_DIGITS)) begin
         buff_q     <= {buff_q[DATA_W-DIGIT_W-1:0], pending_q};
         buff_cnt_q <= buff_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) begin
         same_q   <= 1'b0;
         master_q <= 1'b0;
      end else begin
         same_q   <= (mem_cnt_q == buff_cnt_q) && (mem_cnt_q != '0) && (mem_q == buff_q);
         master_q <= (buff_cnt_q == CNT_W'(MASTER_LEN)) && (buff_q[MPSW_W-1:0] == MASTER_PSW);
      end
   end

   assign input_valid_o  = valid_q;
   assign same_o         = same_q;
   assign master_same_o  = master_q;
   assign mem_limit_o    = (mem_cnt_q == CNT_W'(MAX_DIGITS));
   assign buff_limit_o   = (buff_cnt_q == CNT_W'(MAX_DIGITS));
   assign key_map_o      = key_map;
   assign shuffle_busy_o = busy;

endmodule

// File: tb/tb_psw_datapath.sv
module tb_psw_datapath;

   localparam int MAXD = 8;

   logic        clk = 1'b0;
   logic        nreset_i = 1'b0;
   logic [9:0]  key_i = '0;
   logic        shuffle_init_i = 1'b0;
   logic        mem_rst_i = 1'b0, mem_sl_i = 1'b0;
   logic        buff_rst_i = 1'b0, buff_sl_i = 1'b0;
   logic        input_valid_o, same_o, master_same_o, mem_limit_o, buff_limit_o;
   logic [39:0] key_map_o;
   logic        shuffle_busy_o;

   int vectors = 0;
   int miscompares = 0;

   int          map_m[10];
   int          mem_m[$];
   int          buff_m[$];
   int          pend_m;
   logic [15:0] lfsr_m;

   psw_datapath #(
      .MAX_DIGITS(8),
      .DIGIT_W   (4),
      .MASTER_LEN(8),
      .MASTER_PSW(32'h2580_1379),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk           (clk),
      .nreset_i      (nreset_i),
      .key_i         (key_i),
      .shuffle_init_i(shuffle_init_i),
      .mem_rst_i     (mem_rst_i),
      .mem_sl_i      (mem_sl_i),
      .buff_rst_i    (buff_rst_i),
      .buff_sl_i     (buff_sl_i),
      .input_valid_o (input_valid_o),
      .same_o        (same_o),
      .master_same_o (master_same_o),
      .mem_limit_o   (mem_limit_o),
      .buff_limit_o  (buff_limit_o),
      .key_map_o     (key_map_o),
      .shuffle_busy_o(shuffle_busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      logic fb;
      fb = l[0] ^ l[2] ^ l[3] ^ l[5];
      return {fb, l[15:1]};
   endfunction

   // free-running reference LFSR: advances on every clock out of reset
   always @(posedge clk or negedge nreset_i)
      if (!nreset_i) lfsr_m <= 16'hACE1;
      else           lfsr_m <= lfsr_next(lfsr_m);

   function automatic logic [39:0] map_word();
      logic [39:0] w;
      w = '0;
      for (int b = 0; b < 10; b++) w[4*b +: 4] = 4'(map_m[b]);
      return w;
   endfunction

   function automatic logic [31:0] pack_model(input bit is_buff);
      logic [31:0] w;
      w = '0;
      if (is_buff) foreach (buff_m[k]) w = (w << 4) | 32'(buff_m[k]);
      else         foreach (mem_m[k])  w = (w << 4) | 32'(mem_m[k]);
      return w;
   endfunction

   function automatic bit model_same();
      if (mem_m.size() != buff_m.size() || mem_m.size() == 0) return 1'b0;
      foreach (mem_m[k]) if (mem_m[k] != buff_m[k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_master();
      int mp[8] = '{2, 5, 8, 0, 1, 3, 7, 9};
      if (buff_m.size() != 8) return 1'b0;
      for (int k = 0; k < 8; k++) if (buff_m[k] != mp[k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int b = 0; b < 10; b++) map_m[b] = b;
      mem_m.delete();
      buff_m.delete();
      pend_m = 0;
   endtask

   task automatic enter_digit(input int d);
      int b, seen;
      b = 0;
      for (int k = 0; k < 10; k++) if (map_m[k] == d) b = k;
      key_i = 10'd1 << b;
      repeat (3) tick();
      key_i = '0;
      seen = 0;
      repeat (6) begin
         tick();
         if (input_valid_o === 1'b1) seen++;
      end
      vectors++;
      if (seen != 1) begin
         miscompares++;
         $display("FAIL enter_digit(%0d): pulses=%0d expected 1", d, seen);
      end
      pend_m = d;
   endtask

   task automatic shift(input bit is_buff);
      if (is_buff) buff_sl_i = 1'b1; else mem_sl_i = 1'b1;
      tick();
      buff_sl_i = 1'b0;
      mem_sl_i  = 1'b0;
      tick();
      if (is_buff) begin
         if (buff_m.size() < MAXD) buff_m.push_back(pend_m);
      end else begin
         if (mem_m.size() < MAXD) mem_m.push_back(pend_m);
      end
   endtask

   task automatic clear_regs(input bit m, input bit b);
      mem_rst_i  = m;
      buff_rst_i = b;
      tick();
      mem_rst_i  = 1'b0;
      buff_rst_i = 1'b0;
      tick();
      if (m) mem_m.delete();
      if (b) buff_m.delete();
   endtask

   task automatic check_regs(input string tag);
      vectors++;
      if (dut.mem_q !== pack_model(0)) begin
         miscompares++;
         $display("FAIL %s mem_data: got %h expected %h", tag, dut.mem_q, pack_model(0));
      end
      vectors++;
      if (dut.mem_cnt_q !== 4'(mem_m.size())) begin
         miscompares++;
         $display("FAIL %s mem_count: got %0d expected %0d", tag, dut.mem_cnt_q, mem_m.size());
      end
      vectors++;
      if (dut.buff_q !== pack_model(1)) begin
         miscompares++;
         $display("FAIL %s buff_data: got %h expected %h", tag, dut.buff_q, pack_model(1));
      end
      vectors++;
      if (dut.buff_cnt_q !== 4'(buff_m.size())) begin
         miscompares++;
         $display("FAIL %s buff_count: got %0d expected %0d", tag, dut.buff_cnt_q, buff_m.size());
      end
   endtask

   task automatic check_flags(input string tag);
      vectors++;
      if (same_o !== model_same()) begin
         miscompares++;
         $display("FAIL %s same_o: got %b expected %b", tag, same_o, model_same());
      end
      vectors++;
      if (master_same_o !== model_master()) begin
         miscompares++;
         $display("FAIL %s master_same_o: got %b expected %b", tag, master_same_o, model_master());
      end
      vectors++;
      if (mem_limit_o !== (mem_m.size() == MAXD) || buff_limit_o !== (buff_m.size() == MAXD)) begin
         miscompares++;
         $display("FAIL %s limits: got mem=%b buff=%b expected mem=%b buff=%b", tag,
                  mem_limit_o, buff_limit_o, mem_m.size() == MAXD, buff_m.size() == MAXD);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      vectors++;
      if ({input_valid_o, same_o, master_same_o, mem_limit_o, buff_limit_o, shuffle_busy_o} !== 6'b0) begin
         miscompares++;
         $display("FAIL %s flags: got %b expected 000000", tag,
                  {input_valid_o, same_o, master_same_o, mem_limit_o, buff_limit_o, shuffle_busy_o});
      end
      vectors++;
      if (key_map_o !== 40'h98_7654_3210) begin
         miscompares++;
         $display("FAIL %s key_map_o: got %h expected 9876543210", tag, key_map_o);
      end
   endtask

   task automatic test_reset();
      nreset_i = 1'b0;
      repeat (2) tick();
      check_idle_outputs("reset_held");
      nreset_i = 1'b1;
      tick();
      model_reset();
      check_idle_outputs("reset_release");
      check_regs("reset_release");
   endtask

   task automatic test_press_latency();
      key_i = 10'd1 << 3;
      repeat (3) tick();
      key_i = '0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         vectors++;
         if (input_valid_o !== (k == 3)) begin
            miscompares++;
            $display("FAIL latency cycle+%0d: valid got %b expected %b", k, input_valid_o, k == 3);
         end
      end
      pend_m = 3;
      shift(0);
      vectors++;
      if (dut.mem_q[3:0] !== 4'd3) begin
         miscompares++;
         $display("FAIL latency mem_low_nibble: got %0d expected 3", dut.mem_q[3:0]);
      end
      check_regs("latency_shift");
   endtask

   task automatic test_same();
      int n, digs[4];
      clear_regs(1, 1);
      for (int d = 1; d <= 4; d++) begin
         enter_digit(d); shift(0);
         enter_digit(d); shift(1);
      end
      vectors++;
      if (same_o !== 1'b1) begin
         miscompares++;
         $display("FAIL same_1234: got %b expected 1", same_o);
      end
      check_regs("same_1234");
      clear_regs(0, 1);
      for (int d = 1; d <= 3; d++) begin enter_digit(d); shift(1); end
      check_flags("same_123");
      enter_digit(5); shift(1);
      check_flags("same_1235");
      clear_regs(1, 1);
      check_flags("same_empty");
      repeat (4) begin
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            digs[k] = $urandom_range(0, 9);
            enter_digit(digs[k]); shift(0);
         end
         if ($urandom_range(0, 1) == 1) digs[$urandom_range(0, n-1)] = $urandom_range(0, 9);
         for (int k = 0; k < n; k++) begin enter_digit(digs[k]); shift(1); end
         check_flags("same_random");
         check_regs("same_random");
         clear_regs(1, 1);
      end
   endtask

   task automatic test_limit();
      clear_regs(1, 1);
      for (int k = 0; k < MAXD; k++) begin
         enter_digit($urandom_range(0, 9));
         shift(1);
      end
      vectors++;
      if (buff_limit_o !== 1'b1) begin
         miscompares++;
         $display("FAIL limit_full: buff_limit got %b expected 1", buff_limit_o);
      end
      check_regs("limit_full");
      enter_digit($urandom_range(0, 9));
      shift(1);
      check_regs("limit_extra_sl");
      check_flags("limit_extra_sl");
      buff_rst_i = 1'b1;
      buff_sl_i  = 1'b1;
      tick();
      buff_rst_i = 1'b0;
      buff_sl_i  = 1'b0;
      tick();
      buff_m.delete();
      check_regs("limit_rst_and_sl");
      check_flags("limit_rst_and_sl");
   endtask

   task automatic test_master();
      int mp[8] = '{2, 5, 8, 0, 1, 3, 7, 9};
      clear_regs(1, 1);
      for (int k = 0; k < 8; k++) begin enter_digit(mp[k]); shift(1); end
      vectors++;
      if (master_same_o !== 1'b1) begin
         miscompares++;
         $display("FAIL master_exact: got %b expected 1", master_same_o);
      end
      clear_regs(0, 1);
      for (int k = 0; k < 7; k++) begin enter_digit($urandom_range(0, 9)); shift(1); end
      vectors++;
      if (master_same_o !== 1'b0) begin
         miscompares++;
         $display("FAIL master_7digits: got %b expected 0", master_same_o);
      end
      check_flags("master_7digits");
   endtask

   // mode 0: plain shuffle with a redundant init pulse while busy
   // mode 1: a press that both starts and completes inside the busy window
   // mode 2: a press that starts while busy and completes after it
   task automatic do_shuffle(input int mode, input int btn);
      logic [15:0] l;
      int g[10];
      int busy_cnt, pulses, mask, j, t;
      shuffle_init_i = 1'b1;
      tick();
      shuffle_init_i = 1'b0;
      l = lfsr_m;
      g = map_m;
      for (int i = 9; i >= 1; i--) begin
         j = (int'(l[7:0]) * (i + 1)) >> 8;
         t = g[i]; g[i] = g[j]; g[j] = t;
         l = lfsr_next(l);
      end
      busy_cnt = 0;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         if (shuffle_busy_o === 1'b1) busy_cnt++;
         if (input_valid_o === 1'b1) pulses++;
         shuffle_init_i = (mode == 0 && k == 3);
         if (mode == 1) key_i = (k >= 1 && k < 4) ? (10'd1 << btn) : 10'd0;
         if (mode == 2) key_i = (k >= 5 && k < 12) ? (10'd1 << btn) : 10'd0;
         tick();
      end
      shuffle_init_i = 1'b0;
      key_i = '0;
      map_m = g;
      vectors++;
      if (busy_cnt != 9) begin
         miscompares++;
         $display("FAIL shuffle_busy_cycles mode%0d: got %0d expected 9", mode, busy_cnt);
      end
      vectors++;
      if (key_map_o !== map_word()) begin
         miscompares++;
         $display("FAIL shuffle_map mode%0d: got %h expected %h", mode, key_map_o, map_word());
      end
      mask = 0;
      for (int b = 0; b < 10; b++) mask |= 1 << int'(key_map_o[4*b +: 4]);
      vectors++;
      if (mask != 1023) begin
         miscompares++;
         $display("FAIL shuffle_permutation mode%0d: digit mask got %h expected 3ff", mode, mask);
      end
      vectors++;
      if (pulses != ((mode == 2) ? 1 : 0)) begin
         miscompares++;
         $display("FAIL shuffle_press mode%0d: pulses got %0d expected %0d", mode, pulses, (mode == 2) ? 1 : 0);
      end
      if (mode == 2) pend_m = map_m[btn];
      vectors++;
      if (dut.pending_q !== 4'(pend_m)) begin
         miscompares++;
         $display("FAIL shuffle_pending mode%0d: got %0d expected %0d", mode, dut.pending_q, pend_m);
      end
   endtask

   task automatic test_shuffle();
      repeat ($urandom_range(0, 20)) tick();
      do_shuffle(0, 0);
   endtask

   task automatic test_post_shuffle();
      int seen;
      key_i = 10'd1;
      repeat (3) tick();
      key_i = '0;
      seen = 0;
      repeat (6) begin
         tick();
         if (input_valid_o === 1'b1) seen++;
      end
      pend_m = map_m[0];
      vectors++;
      if (seen != 1 || dut.pending_q !== 4'(map_m[0])) begin
         miscompares++;
         $display("FAIL post_shuffle_button0: pulses=%0d pending=%0d expected 1 pulse digit %0d",
                  seen, dut.pending_q, map_m[0]);
      end
      clear_regs(1, 1);
      shift(0);
      repeat (3) begin enter_digit($urandom_range(0, 9)); shift(0); end
      check_regs("post_shuffle");
   endtask

   task automatic test_busy_discard();
      do_shuffle(1, $urandom_range(0, 9));
      do_shuffle(2, $urandom_range(0, 9));
   endtask

   task automatic test_bad_press();
      int seen, a, b;
      for (int r = 0; r < 3; r++) begin
         a = (r == 0) ? 2 : $urandom_range(0, 9);
         b = (r == 0) ? 5 : (a + $urandom_range(1, 9)) % 10;
         key_i = (10'd1 << a) | (10'd1 << b);
         repeat (3) tick();
         key_i = '0;
         seen = 0;
         repeat (8) begin
            tick();
            if (input_valid_o === 1'b1) seen++;
         end
         vectors++;
         if (seen != 0 || dut.pending_q !== 4'(pend_m)) begin
            miscompares++;
            $display("FAIL bad_press %0d+%0d: pulses=%0d pending=%0d expected 0 pulses pending %0d",
                     a, b, seen, dut.pending_q, pend_m);
         end
      end
   endtask

   task automatic test_reset_mid_shuffle();
      shuffle_init_i = 1'b1;
      tick();
      shuffle_init_i = 1'b0;
      repeat (4) tick();
      nreset_i = 1'b0;
      #2;
      check_idle_outputs("reset_mid_shuffle");
      tick();
      nreset_i = 1'b1;
      tick();
      model_reset();
      check_idle_outputs("reset_mid_release");
      check_regs("reset_mid_release");
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_same();
      test_limit();
      test_master();
      test_shuffle();
      test_post_shuffle();
      test_busy_discard();
      test_bad_press();
      test_reset_mid_shuffle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/psw_datapath.md
Name: psw_datapath

Overview:
Password datapath that sits opposite the doorlock control FSM. It consumes mem_rst/mem_sl/buff_rst/buff_sl/shuffle_init and returns input_valid/same/master_same/buff_limit/mem_limit. It holds the stored-password shift register (mem) and the entry buffer (buff), and decodes raw keypad buttons through a shufflable key map. It also runs the key-map shuffle sequence.

Parameters:
MAX_DIGITS, 8, capacity of mem and buff in digits (2..15)
DIGIT_W, 4, bits per digit
MASTER_LEN, 8, digit count of master password
MASTER_PSW, 32'h2580_1379, master password packed MSD-first; low MASTER_LEN*DIGIT_W bits used
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock, all flops on posedge
nreset_i  in  1  reset; asynchronous, active-low
key_i  in  10  raw button levels, bit b = physical button b; asynchronous to clk
shuffle_init_i  in  1  one-cycle pulse; start key-map shuffle
mem_rst_i  in  1  clear mem and mem count
mem_sl_i  in  1  shift pending digit into mem
buff_rst_i  in  1  clear buff and buff count
buff_sl_i  in  1  shift pending digit into buff
input_valid_o  out  1  one-cycle pulse; a digit was accepted
same_o  out  1  buff equals mem
master_same_o  out  1  buff equals MASTER_PSW
mem_limit_o  out  1  mem count == MAX_DIGITS
buff_limit_o  out  1  buff count == MAX_DIGITS
key_map_o  out  40  digit shown on button b at bits [4b+3:4b], for the display
shuffle_busy_o  out  1  shuffle sequence in progress

Behaviour:
- Reset: all outputs 0, except key_map_o = 40'h98_7654_3210 (identity map).
- Reset also clears mem, buff, counts, pending digit and sync flops, and sets LFSR = LFSR_SEED. Reset during a shuffle aborts it and restores the identity map.
- Key capture: key_i passes through a 2-FF synchronizer to give key_s. A press starts when key_s != 0.
- If key_s is ever non-one-hot during a press, the press is marked bad.
- When key_s returns to 0:
  - good press: pending_digit <= key_map[button] and input_valid_o = 1 for exactly one cycle.
  - bad press: no pulse.
- Latency: input_valid_o is high in cycle N+3 when key_i falls in cycle N.
- pending_digit holds its value until the next accepted press.
- Presses that complete while shuffle_busy_o = 1 are discarded. A press that starts during busy and ends after busy is accepted.
- Shift (mem and buff are identical and independent): on sl, data <= {data[(MAX_DIGITS-1)*DIGIT_W-1:0], pending_digit} and count <= count+1.
  - At count == MAX_DIGITS, sl is ignored: data and count unchanged.
  - rst has priority over sl in the same cycle: data = 0, count = 0.
- Unused high digits are always 0.
- same_o (registered from current regs, 1 cycle after the update) = (mem_count == buff_count) & (mem_count != 0) & (mem_data == buff_data).
- master_same_o (registered) = (buff_count == MASTER_LEN) & (buff low digits == MASTER_PSW).
- Limits are combinational from the counts.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle whether or not a shuffle is running.
- Shuffle FSM, states IDLE and SHUF:
  - IDLE: on shuffle_init_i, go to SHUF with i = 9 and busy = 1. A shuffle_init_i while already busy is ignored.
  - SHUF, each cycle: j = (lfsr[7:0] * (i+1)) >> 8 (range 0..i); swap map[i] and map[j]; i <= i-1.
  - After the i = 1 step (9 cycles total), return to IDLE with busy = 0.
  - The 9-cycle duration matches the control FSM's shuffle window.
- The shuffle does not touch mem, buff or pending_digit.

Decomposition:
- Package psw_pkg: DIGIT_W, NUM_KEYS = 10, KEYMAP_W = 40, LFSR taps, IDENTITY_MAP constant, shuffle state enum {IDLE, SHUF}.
- Sub-module keymap_shuffler contains the LFSR, shuffle FSM and map registers. Its ports are clk, nreset_i, shuffle_init_i, map_o and busy_o.
- Key capture and mem/buff shift registers stay in the top module.

Test Plan:
- Reset release -> all flags 0, key_map_o = 40'h9876543210, busy 0. Hold nreset_i low mid-shuffle -> same values.
- Identity map, press/release button 3 -> input_valid_o is a single pulse exactly 3 cycles after release. Then pulse mem_sl_i -> mem low nibble = 3, mem_count = 1.
- Store 1,2,3,4 in mem and 1,2,3,4 in buff -> same_o = 1. Next: buff 1,2,3 -> 0; buff 1,2,3,5 -> 0; both empty -> 0.
- MAX_DIGITS sl into buff -> buff_limit_o = 1; a further sl leaves data/count unchanged. buff_rst_i + buff_sl_i in the same cycle -> count 0, data 0.
- Enter 2,5,8,0,1,3,7,9 into buff -> master_same_o = 1. Enter any 7 digits -> 0.
- Pulse shuffle_init_i at a known cycle after reset -> busy for exactly 9 cycles; final map is a permutation of 0..9 equal to the golden model (seed ACE1, same start cycle).
- After the shuffle, pressing button 0 yields digit map[0].
- Press completing during busy -> no pulse. Buttons 2+5 held together -> no pulse.
